emu_run_ctrl: RTL and testbench
===============================

// Module: emu_run_ctrl
// PURPOSE
// Run-control sequencer for the link emulator. It runs on the free-running clock and owns the clkgate
// enable that produces clk_sys. It resets the DUT, runs until emulated time reaches a stop value, and
// supports pause, resume and single/multi-cycle stepping. It also counts gated cycles and raises sim_done.
// PARAMETERS
// TIME_WIDTH   default 32  width of emulated-time values (matches time_package TIME_FORMAT)
// STEP_WIDTH   default 16  width of step-count request
// RST_CYCLES   default 8   number of gated clk_sys cycles for which dut_rst is held
// CNT_WIDTH    default 32  width of gated-cycle counter
// PORTS
// clk_orig    in   1           free-running clock; all logic on posedge
// rst         in   1           asynchronous, active-high reset
// start       in   1           pulse: begin new run (accepted in IDLE or DONE only)
// pause       in   1           pulse: freeze emulation (accepted in RUN)
// resume      in   1           pulse: continue (accepted in PAUSED)
// step_req    in   1           pulse: run step_count gated cycles (accepted in PAUSED)
// step_count  in   STEP_WIDTH  cycles per step, sampled with step_req
// time_stop   in   TIME_WIDTH  stop time, unsigned, sampled when start is accepted
// time_curr   in   TIME_WIDTH  current emulated time from time_manager
// gate_en     out  1           clkgate enable for clk_sys
// dut_rst     out  1           synchronous reset to the emulated DUT
// running     out  1           1 in RUN or STEP
// paused      out  1           1 in PAUSED
// sim_done    out  1           sticky; cleared by rst or an accepted start
// cyc_cnt     out  CNT_WIDTH   number of cycles with gate_en=1 since last start; saturates at all-ones
// BEHAVIOUR
// - Reset (async): state=IDLE; gate_en=0, dut_rst=0, running=0, paused=0, sim_done=0, cyc_cnt=0, step counter=0.
//   Reset mid-run aborts immediately with no completion of any step.
// - All outputs are registered. Each output changes on the clk_orig edge that performs the state transition.
// - States and transitions (evaluated each posedge, listed in priority order):
//   IDLE:    start -> DUT_RST; latch time_stop; sim_done<=0; cyc_cnt<=0; reset counter<=RST_CYCLES.
//   DUT_RST: gate_en=1, dut_rst=1. The counter decrements each cycle. At counter==1 -> RUN.
//            This gives exactly RST_CYCLES gated cycles with dut_rst=1. pause, resume and step_req are ignored.
//   RUN:     gate_en=1. (time_curr >= stop) -> DONE. Otherwise pause -> PAUSED.
//   PAUSED:  gate_en=0. resume -> RUN. Otherwise step_req with step_count!=0 -> STEP, loading the step counter.
//            step_req with step_count==0 is ignored.
//   STEP:    gate_en=1. (time_curr >= stop) -> DONE. Otherwise at counter==1 -> PAUSED; else decrement.
//            This gives exactly step_count gated cycles. pause, resume and step_req are ignored.
//   DONE:    gate_en=0, sim_done=1. start -> DUT_RST, handled as in IDLE.
// - The stop check has priority over pause in the same cycle. The time compare is unsigned, full TIME_WIDTH.
// - start is ignored outside IDLE and DONE.
// - cyc_cnt increments on every edge where gate_en is currently 1, and holds at 2^CNT_WIDTH-1.
// - Because time_curr is produced in the gated domain, it is frozen while gate_en=0.
//   At most one extra gated cycle can occur after the stop condition becomes true. This overshoot is accepted.
// - gate_en may only toggle on posedge clk_orig. clkgate latches it to remain glitch-free.
// STRUCTURE
// - emu_ctrl_package: typedef enum logic [2:0] {IDLE, DUT_RST, RUN, PAUSED, STEP, DONE} run_state_t;
//   it also holds the RST_CYCLES default. TIME_FORMAT is reused from time_package.
// - One FSM plus one shared down-counter (width max(STEP_WIDTH, clog2(RST_CYCLES+1))).
// - Sub-module: sat_counter (saturating up-counter, parameter WIDTH) for cyc_cnt.
// TESTING
// 1. rst, then start with time_stop=100; time_curr ramps 10 per gated cycle
//    -> dut_rst=1 for 8 cycles; RUN; DONE on the cycle after time_curr=100; sim_done=1; gate_en=0.
// 2. In RUN, pulse pause -> gate_en=0 on the next edge and cyc_cnt frozen;
//    resume -> gate_en=1 on the next edge and counting continues.
// 3. In PAUSED, step_req with step_count=5 -> exactly 5 cycles with gate_en=1, then PAUSED; cyc_cnt += 5.
//    step_count=0 -> no gate_en pulse.
// 4. pause asserted on the same cycle the stop condition becomes true -> DONE, not PAUSED.
//    The stop condition hit during STEP -> DONE.
// 5. Assert rst mid-STEP with 3 cycles remaining -> all outputs 0 asynchronously, state IDLE.
//    start is ignored while in RUN.
// 6. CNT_WIDTH=4, run 20 gated cycles -> cyc_cnt saturates at 15.
//    start from DONE -> cyc_cnt=0 and sim_done=0 on the next edge.

Source files
------------

// File: rtl/emu_run_ctrl_pkg.sv
`default_nettype none
// emu_run_ctrl_pkg: shared state type, defaults and helpers for the emulator run-control sequencer.
// Revision 1.0
package emu_run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DUT_RST = 3'd1,
    RUN     = 3'd2,
    PAUSED  = 3'd3,
    STEP    = 3'd4,
    DONE    = 3'd5
  } run_state_t;

  // Emulated-time width shared with the time manager.
  localparam int TIME_FORMAT        = 32;
  localparam int RST_CYCLES_DEFAULT = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/emu_run_ctrl_if.sv
`default_nettype none
// emu_run_ctrl_if: run-control command/status bundle between the host side and the sequencer.
// Revision 1.0
interface emu_run_ctrl_if #(
  parameter int TIME_WIDTH = 32,
  parameter int STEP_WIDTH = 16,
  parameter int CNT_WIDTH  = 32
);

  logic                  start;
  logic                  pause;
  logic                  resume;
  logic                  step_req;
  logic [STEP_WIDTH-1:0] step_count;
  logic [TIME_WIDTH-1:0] time_stop;
  logic [TIME_WIDTH-1:0] time_curr;

  logic                  gate_en;
  logic                  dut_rst;
  logic                  running;
  logic                  paused;
  logic                  sim_done;
  logic [CNT_WIDTH-1:0]  cyc_cnt;

  modport master (
    output start, pause, resume, step_req, step_count, time_stop, time_curr,
    input  gate_en, dut_rst, running, paused, sim_done, cyc_cnt
  );

  modport slave (
    input  start, pause, resume, step_req, step_count, time_stop, time_curr,
    output gate_en, dut_rst, running, paused, sim_done, cyc_cnt
  );

endinterface
`default_nettype wire

// File: rtl/emu_run_ctrl_sat_counter.sv
`default_nettype none
// emu_run_ctrl_sat_counter: up-counter with synchronous clear that holds at all-ones.
// Revision 1.0
module emu_run_ctrl_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_VAL)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/emu_run_ctrl.sv
`default_nettype none
// emu_run_ctrl: run/pause/step sequencer owning the clk_sys gate enable of the link emulator.
// Revision 1.0
module emu_run_ctrl
  import emu_run_ctrl_pkg::*;
#(
  parameter int TIME_WIDTH = TIME_FORMAT,
  parameter int STEP_WIDTH = 16,
  parameter int RST_CYCLES = RST_CYCLES_DEFAULT,
  parameter int CNT_WIDTH  = 32
) (
  input  logic           clk_orig,
  input  logic           rst,
  emu_run_ctrl_if.slave  bus
);

  localparam int DCNT_W = max_int(STEP_WIDTH, $clog2(RST_CYCLES + 1));
  // A zero reset length would never reach the exit count, so it degrades to one cycle.
  localparam logic [DCNT_W-1:0] RST_LOAD = (RST_CYCLES < 1) ? DCNT_W'(1) : DCNT_W'(RST_CYCLES);

  localparam logic [2:0] S_IDLE    = 3'(IDLE);
  localparam logic [2:0] S_DUT_RST = 3'(DUT_RST);
  localparam logic [2:0] S_RUN     = 3'(RUN);
  localparam logic [2:0] S_PAUSED  = 3'(PAUSED);
  localparam logic [2:0] S_STEP    = 3'(STEP);
  localparam logic [2:0] S_DONE    = 3'(DONE);

  logic [2:0]            state;
  logic [DCNT_W-1:0]     dcnt;
  logic [TIME_WIDTH-1:0] stop_q;
  logic                  gate_q;
  logic                  dut_rst_q;
  logic                  running_q;
  logic                  paused_q;
  logic                  done_q;
  logic                  stop_hit;
  logic                  start_ok;
  logic                  dcnt_last;

  assign stop_hit  = (bus.time_curr >= stop_q);
  assign start_ok  = bus.start && ((state == S_IDLE) || (state == S_DONE));
  assign dcnt_last = (dcnt == DCNT_W'(1));

  always_ff @(posedge clk_orig or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      dcnt      <= '0;
      stop_q    <= '0;
      gate_q    <= 1'b0;
      dut_rst_q <= 1'b0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state     <= S_DUT_RST;
            stop_q    <= bus.time_stop;
            dcnt      <= RST_LOAD;
            done_q    <= 1'b0;
            gate_q    <= 1'b1;
            dut_rst_q <= 1'b1;
          end
        end

        S_DUT_RST: begin
          if (dcnt_last) begin
            state     <= S_RUN;
            dcnt      <= '0;
            dut_rst_q <= 1'b0;
            running_q <= 1'b1;
          end else begin
            dcnt <= dcnt - DCNT_W'(1);
          end
        end

        // Stop detection outranks a same-cycle pause request.
        S_RUN: begin
          if (stop_hit) begin
            state     <= S_DONE;
            gate_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (bus.pause) begin
            state     <= S_PAUSED;
            gate_q    <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b1;
          end
        end

        S_PAUSED: begin
          if (bus.resume) begin
            state     <= S_RUN;
            gate_q    <= 1'b1;
            running_q <= 1'b1;
            paused_q  <= 1'b0;
          end else if (bus.step_req && (bus.step_count != '0)) begin
            state     <= S_STEP;
            dcnt      <= DCNT_W'(bus.step_count);
            gate_q    <= 1'b1;
            running_q <= 1'b1;
            paused_q  <= 1'b0;
          end
        end

        S_STEP: begin
          if (stop_hit) begin
            state     <= S_DONE;
            dcnt      <= '0;
            gate_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (dcnt_last) begin
            state     <= S_PAUSED;
            dcnt      <= '0;
            gate_q    <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b1;
          end else begin
            dcnt <= dcnt - DCNT_W'(1);
          end
        end

        default: begin
          state     <= S_IDLE;
          dcnt      <= '0;
          gate_q    <= 1'b0;
          dut_rst_q <= 1'b0;
          running_q <= 1'b0;
          paused_q  <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  // Counts edges on which the gate is open; an accepted start restarts the count.
  emu_run_ctrl_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_cyc_cnt (
    .clk   (clk_orig),
    .rst   (rst),
    .clr   (start_ok),
    .inc   (gate_q),
    .count (bus.cyc_cnt)
  );

  assign bus.gate_en  = gate_q;
  assign bus.dut_rst  = dut_rst_q;
  assign bus.running  = running_q;
  assign bus.paused   = paused_q;
  assign bus.sim_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_emu_run_ctrl.sv
`default_nettype none
// tb_emu_run_ctrl: table vectors, directed corner sequences and random stimulus against a phase model.
// Revision 1.0
module tb_emu_run_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  emu_run_ctrl_if #(.TIME_WIDTH(32), .STEP_WIDTH(16), .CNT_WIDTH(32)) bus0 ();
  emu_run_ctrl_if #(.TIME_WIDTH(32), .STEP_WIDTH(16), .CNT_WIDTH(4))  bus1 ();

  emu_run_ctrl #(.TIME_WIDTH(32), .STEP_WIDTH(16), .RST_CYCLES(8), .CNT_WIDTH(32)) dut0 (
    .clk_orig (clk),
    .rst      (rst),
    .bus      (bus0.slave)
  );

  emu_run_ctrl #(.TIME_WIDTH(32), .STEP_WIDTH(16), .RST_CYCLES(8), .CNT_WIDTH(4)) dut1 (
    .clk_orig (clk),
    .rst      (rst),
    .bus      (bus1.slave)
  );

  // Behavioural model: a named phase, remaining cycles in the current timed phase, gated-edge tally.
  typedef enum int {P_IDLE, P_RESET, P_RUN, P_HOLD, P_STEP, P_FIN} phase_t;
  phase_t      ph     = P_IDLE;
  int          left   = 0;
  longint      m_cnt  = 0;
  logic [31:0] m_stop = '0;
  logic [31:0] tc     = '0;
  logic [31:0] ts     = '0;

  function automatic bit e_gate();
    return (ph == P_RESET) || (ph == P_RUN) || (ph == P_STEP);
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void compare_model(input string tag);
    longint e0 = (m_cnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt;
    longint e1 = (m_cnt > 15) ? 15 : m_cnt;
    chk({tag, ".gate_en"},  64'(bus0.gate_en),  64'(e_gate()));
    chk({tag, ".dut_rst"},  64'(bus0.dut_rst),  64'(ph == P_RESET));
    chk({tag, ".running"},  64'(bus0.running),  64'((ph == P_RUN) || (ph == P_STEP)));
    chk({tag, ".paused"},   64'(bus0.paused),   64'(ph == P_HOLD));
    chk({tag, ".sim_done"}, 64'(bus0.sim_done), 64'(ph == P_FIN));
    chk({tag, ".cyc_cnt"},  64'(bus0.cyc_cnt),  64'(e0));
    chk({tag, ".gate_en4"}, 64'(bus1.gate_en),  64'(e_gate()));
    chk({tag, ".cyc_cnt4"}, 64'(bus1.cyc_cnt),  64'(e1));
  endfunction

  task automatic drive(input bit s, input bit p, input bit r, input bit sr, input logic [15:0] sc);
    bus0.start = s;  bus0.pause = p;  bus0.resume = r;  bus0.step_req = sr;  bus0.step_count = sc;
    bus1.start = s;  bus1.pause = p;  bus1.resume = r;  bus1.step_req = sr;  bus1.step_count = sc;
    bus0.time_stop = ts;  bus1.time_stop = ts;
    bus0.time_curr = tc;  bus1.time_curr = tc;
  endtask

  // Time manager stand-in: zeroed by gated reset cycles, +10 per gated cycle otherwise.
  task automatic model_edge(input bit s, input bit p, input bit r, input bit sr, input logic [15:0] sc,
                            output logic [31:0] tc_next);
    bit g_old   = e_gate();
    bit rst_old = (ph == P_RESET);
    bit hit     = (tc >= m_stop);
    tc_next = rst_old ? 32'd0 : (g_old ? tc + 32'd10 : tc);
    if (((ph == P_IDLE) || (ph == P_FIN)) && s) begin
      ph = P_RESET; left = 8; m_stop = ts; m_cnt = 0;
    end else begin
      if (g_old) m_cnt++;
      case (ph)
        P_RESET: begin left--; if (left == 0) ph = P_RUN; end
        P_RUN:   if (hit) ph = P_FIN; else if (p) ph = P_HOLD;
        P_HOLD:  if (r) ph = P_RUN; else if (sr && (sc != 0)) begin ph = P_STEP; left = int'(sc); end
        P_STEP:  if (hit) ph = P_FIN; else begin left--; if (left == 0) ph = P_HOLD; end
        default: ;
      endcase
    end
  endtask

  task automatic tick(input bit s, input bit p, input bit r, input bit sr, input logic [15:0] sc);
    logic [31:0] tc_next;
    @(negedge clk);
    drive(s, p, r, sr, sc);
    @(posedge clk);
    model_edge(s, p, r, sr, sc, tc_next);
    #1;
    tc = tc_next;
    compare_model("tick");
  endtask

  task automatic idle_tick();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    ph = P_IDLE; left = 0; m_cnt = 0; m_stop = '0; tc = '0;
    compare_model(tag);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_running(input string tag);
    for (int i = 0; i < 20 && !bus0.running; i++) idle_tick();
    chk(tag, 64'(bus0.running), 64'd1);
  endtask

  typedef struct {
    bit s, p, r, sr;
    logic [15:0] sc;
    int reps;
    bit g, dr, run, pa, dn;
    int cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input bit s, p, r, sr, input int sc, input int reps,
                              input bit g, dr, run, pa, dn, input int cnt);
    vec_t v;
    v.s = s; v.p = p; v.r = r; v.sr = sr; v.sc = 16'(sc); v.reps = reps;
    v.g = g; v.dr = dr; v.run = run; v.pa = pa; v.dn = dn; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n;
    logic [31:0] pre;
    bit found;

    //          s  p  r  sr sc reps  g  dr run pa dn cnt
    vt.push_back(mk(1, 0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 7,   1, 1, 0, 0, 0, 7));
    vt.push_back(mk(0, 0, 0, 0, 0, 1,   1, 0, 1, 0, 0, 8));
    vt.push_back(mk(1, 0, 0, 0, 0, 1,   1, 0, 1, 0, 0, 9));
    vt.push_back(mk(0, 1, 0, 0, 0, 1,   0, 0, 0, 1, 0, 10));
    vt.push_back(mk(0, 0, 0, 0, 0, 3,   0, 0, 0, 1, 0, 10));
    vt.push_back(mk(0, 0, 0, 1, 0, 1,   0, 0, 0, 1, 0, 10));
    vt.push_back(mk(0, 0, 1, 0, 0, 1,   1, 0, 1, 0, 0, 10));
    vt.push_back(mk(0, 0, 0, 0, 0, 2,   1, 0, 1, 0, 0, 12));
    vt.push_back(mk(0, 1, 0, 0, 0, 1,   0, 0, 0, 1, 0, 13));
    vt.push_back(mk(0, 0, 0, 1, 5, 1,   1, 0, 1, 0, 0, 13));
    vt.push_back(mk(0, 1, 1, 1, 3, 4,   1, 0, 1, 0, 0, 17));
    vt.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 18));
    vt.push_back(mk(0, 0, 1, 0, 0, 1,   1, 0, 1, 0, 0, 18));

    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    repeat (3) @(negedge clk);
    compare_model("reset");
    rst = 1'b0;

    ts = 32'd1000;
    foreach (vt[i]) begin
      for (int k = 0; k < vt[i].reps; k++) tick(vt[i].s, vt[i].p, vt[i].r, vt[i].sr, vt[i].sc);
      chk($sformatf("vec%0d.gate_en", i),  64'(bus0.gate_en),  64'(vt[i].g));
      chk($sformatf("vec%0d.dut_rst", i),  64'(bus0.dut_rst),  64'(vt[i].dr));
      chk($sformatf("vec%0d.running", i),  64'(bus0.running),  64'(vt[i].run));
      chk($sformatf("vec%0d.paused", i),   64'(bus0.paused),   64'(vt[i].pa));
      chk($sformatf("vec%0d.sim_done", i), 64'(bus0.sim_done), 64'(vt[i].dn));
      chk($sformatf("vec%0d.cyc_cnt", i),  64'(bus0.cyc_cnt),  64'(vt[i].cnt));
      chk($sformatf("vec%0d.cyc_cnt4", i), 64'(bus1.cyc_cnt),  64'((vt[i].cnt > 15) ? 15 : vt[i].cnt));
    end

    // Full run to stop=100 with time ramping 10 per gated cycle.
    async_reset("t1_rst");
    ts = 32'd100;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      pre = tc;
      idle_tick();
      if (bus0.sim_done) begin
        found = 1'b1;
        chk("t1_stop_time_seen", 64'(pre), 64'd100);
        chk("t1_gate_off", 64'(bus0.gate_en), 64'd0);
      end
    end
    chk("t1_done_reached", 64'(found), 64'd1);
    chk("t1_cyc_cnt", 64'(bus0.cyc_cnt), 64'd19);
    chk("t1_cyc_cnt_sat4", 64'(bus1.cyc_cnt), 64'd15);

    // Restart from DONE, then pause on the very cycle the stop condition is seen.
    ts = 32'd50;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    chk("t4_restart_cnt", 64'(bus0.cyc_cnt), 64'd0);
    chk("t4_restart_done", 64'(bus0.sim_done), 64'd0);
    n = 0;
    while (tc != 32'd50 && n < 100) begin idle_tick(); n++; end
    chk("t4_reach_50", 64'(tc), 64'd50);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    chk("t4_pause_vs_stop_done", 64'(bus0.sim_done), 64'd1);
    chk("t4_pause_vs_stop_paused", 64'(bus0.paused), 64'd0);

    // Stop condition reached in the middle of a step.
    ts = 32'd30;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    wait_running("t4s_running");
    tick(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    chk("t4s_paused", 64'(bus0.paused), 64'd1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 16'd7);
    n = 0;
    while (!bus0.sim_done && n < 12) begin idle_tick(); n++; end
    chk("t4s_done", 64'(bus0.sim_done), 64'd1);
    chk("t4s_step_edges", 64'(n), 64'd3);

    // Asynchronous reset with three step cycles still outstanding.
    ts = 32'd1000;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    wait_running("t5_running");
    tick(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 16'd6);
    repeat (3) idle_tick();
    chk("t5_in_step", 64'(bus0.running), 64'd1);
    async_reset("t5_rst_mid_step");
    chk("t5_gate_zero", 64'(bus0.gate_en), 64'd0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    chk("t5_start_after_rst", 64'(bus0.dut_rst), 64'd1);

    // Random command traffic checked against the model every cycle.
    for (int i = 0; i < 2500; i++) begin
      bit s  = ($urandom_range(0, 19) == 0);
      bit p  = ($urandom_range(0, 7) == 0);
      bit r  = ($urandom_range(0, 5) == 0);
      bit sr = ($urandom_range(0, 4) == 0);
      logic [15:0] sc = 16'($urandom_range(0, 6));
      if (s) ts = ($urandom_range(0, 7) == 0) ? (32'h8000_0000 | 32'($urandom_range(0, 255)))
                                             : 32'($urandom_range(0, 400));
      if ($urandom_range(0, 49) == 0) tc = tc + 32'($urandom_range(0, 150));
      if ($urandom_range(0, 399) == 0) async_reset("rnd_rst");
      else tick(s, p, r, sr, sc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
